// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serial deserializer/aligner.
package serdes_pkg;

    typedef enum logic {HUNT, ALIGNED} align_state_e;

    localparam logic [9:0] DEFAULT_SYNC_PATTERN = 10'b0110011010;

    // Widest replicated header the helper below can build.
    localparam int unsigned MAX_REP_W = 4096;

    // Tile the low 'width' bits of 'pattern' 'reps' times; copy 0 lands in the LSBs.
    function automatic logic [MAX_REP_W-1:0] replicate_pattern(
        input logic [MAX_REP_W-1:0] pattern,
        input int unsigned          width,
        input int unsigned          reps
    );
        logic [MAX_REP_W-1:0] mask;
        logic [MAX_REP_W-1:0] rep;
        mask = (MAX_REP_W'(1) << width) - MAX_REP_W'(1);
        rep  = '0;
        for (int unsigned i = 0; i < reps; i++) begin
            rep = rep | ((pattern & mask) << (i * width));
        end
        return rep;
    endfunction

endpackage

// File: rtl/sync_window_det.sv
// Serial shift window plus compare against the replicated frame header.
module sync_window_det
    import serdes_pkg::*;
#(
    parameter int unsigned          DATA_W       = 10,
    parameter logic [DATA_W-1:0]    SYNC_PATTERN = DATA_W'(DEFAULT_SYNC_PATTERN),
    parameter int unsigned          SYNC_REPS    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          data_in,
    output logic [DATA_W*SYNC_REPS-1:0]   window,
    output logic                          match
);

    localparam int unsigned       WIN_W    = DATA_W * SYNC_REPS;
    localparam logic [WIN_W-1:0]  SYNC_REP =
        WIN_W'(replicate_pattern(MAX_REP_W'(SYNC_PATTERN), DATA_W, SYNC_REPS));

    logic [WIN_W-1:0] window_q;

    // Shift in one bit per enabled edge, newest bit at position 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            window_q <= '0;
        end else if (enable) begin
            window_q <= {window_q[WIN_W-2:0], data_in};
        end
    end

    assign window = window_q;
    assign match  = (window_q == SYNC_REP);

endmodule

// File: rtl/deser_align_lock.sv
// 1-bit to DATA_W-bit deserializer with header-based word alignment and lock tracking.
// Optional loss-of-lock timeout enabled by defining DESER_ALIGN_LOCK_LOSS_OF_LOCK_EN.
module deser_align_lock
    import serdes_pkg::*;
#(
    parameter int unsigned          DATA_W             = 10,
    parameter logic [DATA_W-1:0]    SYNC_PATTERN       = DATA_W'(DEFAULT_SYNC_PATTERN),
    parameter int unsigned          SYNC_REPS          = 4,
    parameter int unsigned          LOCK_TIMEOUT_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              data_in,
    input  logic              realign,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              bit_align_done,
    output logic              sync_seen,
    output logic              lock_lost
);

    localparam int unsigned       WIN_W = DATA_W * SYNC_REPS;
    localparam int unsigned       CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    logic [WIN_W-1:0]  window;
    logic              match;
    logic [DATA_W-1:0] word;

    align_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              sync_q, sync_d;
    logic              lost_q, lost_d;

    sync_window_det #(
        .DATA_W       (DATA_W),
        .SYNC_PATTERN (SYNC_PATTERN),
        .SYNC_REPS    (SYNC_REPS)
    ) u_det (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .data_in (data_in),
        .window  (window),
        .match   (match)
    );

    // The word completes with the bit being sampled on this edge.
    assign word = {window[DATA_W-2:0], data_in};

    logic unused_window;
    assign unused_window = ^window[WIN_W-1:DATA_W-1];

`ifdef DESER_ALIGN_LOCK_LOSS_OF_LOCK_EN
    localparam int unsigned WCNT_W = $clog2(LOCK_TIMEOUT_WORDS + 1);
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    // Consecutive non-header words seen while aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = LOCK_TIMEOUT_WORDS;
`endif

    // State, bit counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            sync_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            sync_q     <= sync_d;
            lost_q     <= lost_d;
        end
    end

    // Next-state: hunt for the header train, then frame words on the locked boundary.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        sync_d     = 1'b0;
        lost_d     = 1'b0;
`ifdef DESER_ALIGN_LOCK_LOSS_OF_LOCK_EN
        wcnt_d     = wcnt_q;
`endif
        unique case (state_q)
            HUNT: begin
                if (match && !realign) begin
                    state_d = ALIGNED;
                    // A bit sampled on the locking edge is bit 0 of the first word.
                    cnt_d   = enable ? CNT_W'(1) : '0;
`ifdef DESER_ALIGN_LOCK_LOSS_OF_LOCK_EN
                    wcnt_d  = '0;
`endif
                end
            end
            ALIGNED: begin
                if (realign) begin
                    state_d = HUNT;
                    cnt_d   = '0;
`ifdef DESER_ALIGN_LOCK_LOSS_OF_LOCK_EN
                    wcnt_d  = '0;
`endif
                end else if (enable) begin
                    if (cnt_q == LAST) begin
                        cnt_d      = '0;
                        data_out_d = word;
                        valid_d    = 1'b1;
                        if (word == SYNC_PATTERN) begin
                            sync_d = 1'b1;
`ifdef DESER_ALIGN_LOCK_LOSS_OF_LOCK_EN
                            wcnt_d = '0;
`endif
                        end else begin
`ifdef DESER_ALIGN_LOCK_LOSS_OF_LOCK_EN
                            if (wcnt_q + 1'b1 == WCNT_W'(LOCK_TIMEOUT_WORDS)) begin
                                state_d = HUNT;
                                lost_d  = 1'b1;
                                wcnt_d  = '0;
                            end else begin
                                wcnt_d  = wcnt_q + 1'b1;
                            end
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign data_out       = data_out_q;
    assign data_valid     = valid_q;
    assign bit_align_done = (state_q == ALIGNED);
    assign sync_seen      = sync_q;
    assign lock_lost      = lost_q;

endmodule

// File: tb/tb_deser_align_lock.sv
// Randomized bench with a queue-based reference model for deser_align_lock.
// Checks the DESER_ALIGN_LOCK_LOSS_OF_LOCK_EN behaviour when that macro is defined.
module tb_deser_align_lock;

    localparam int unsigned W    = 10;
    localparam int unsigned REPS = 4;
    localparam int unsigned TO   = 8;
    localparam logic [9:0]  SYNC = 10'b0110011010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       data_in = 1'b0;
    logic       realign = 1'b0;
    logic [9:0] data_out;
    logic       data_valid, bit_align_done, sync_seen, lock_lost;

    deser_align_lock #(
        .DATA_W             (W),
        .SYNC_PATTERN       (SYNC),
        .SYNC_REPS          (REPS),
        .LOCK_TIMEOUT_WORDS (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .data_in        (data_in),
        .realign        (realign),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .bit_align_done (bit_align_done),
        .sync_seen      (sync_seen),
        .lock_lost      (lock_lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the enabled bit history and the bits of the word in progress.
    bit         hist[$];
    bit         wbits[$];
    bit         m_locked = 0;
    int         m_wcnt = 0;
    logic [9:0] exp_dout = '0;
    bit         exp_valid = 0, exp_sync = 0, exp_lost = 0;
    bit         cmp_en = 0;

    function automatic bit hist_match();
        int base;
        if (hist.size() < W * REPS) return 0;
        base = hist.size() - W * REPS;
        for (int i = 0; i < W * REPS; i++) begin
            if (hist[base + i] != SYNC[W - 1 - (i % W)]) return 0;
        end
        return 1;
    endfunction

    task automatic model_edge();
        logic [9:0] w;
        exp_valid = 0;
        exp_sync  = 0;
        exp_lost  = 0;
        if (rst) begin
            hist.delete();
            wbits.delete();
            m_locked = 0;
            m_wcnt   = 0;
            exp_dout = '0;
            return;
        end
        if (!m_locked) begin
            if (hist_match() && !realign) begin
                m_locked = 1;
                m_wcnt   = 0;
                wbits.delete();
                if (enable) wbits.push_back(data_in);
            end
        end else if (realign) begin
            m_locked = 0;
            m_wcnt   = 0;
            wbits.delete();
        end else if (enable) begin
            wbits.push_back(data_in);
            if (wbits.size() == W) begin
                w = '0;
                foreach (wbits[i]) w = {w[8:0], wbits[i]};
                wbits.delete();
                exp_dout  = w;
                exp_valid = 1;
                if (w == SYNC) begin
                    exp_sync = 1;
                    m_wcnt   = 0;
                end else begin
                    m_wcnt++;
`ifdef DESER_ALIGN_LOCK_LOSS_OF_LOCK_EN
                    if (m_wcnt == TO) begin
                        exp_lost = 1;
                        m_locked = 0;
                        m_wcnt   = 0;
                    end
`endif
                end
            end
        end
        if (enable) begin
            hist.push_back(data_in);
            while (hist.size() > W * REPS) void'(hist.pop_front());
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("data_out", 32'(data_out), 32'(exp_dout));
            chk("data_valid", 32'(data_valid), 32'(exp_valid));
            chk("bit_align_done", 32'(bit_align_done), 32'(m_locked));
            chk("sync_seen", 32'(sync_seen), 32'(exp_sync));
            chk("lock_lost", 32'(lock_lost), 32'(exp_lost));
        end
    end

    // Capture of delivered words for the literal expectations.
    logic [9:0] dut_words[$];
    bit         dut_syncs[$];
    int         n_lost = 0;
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dut_words.push_back(data_out);
            dut_syncs.push_back(sync_seen);
        end
        if (lock_lost === 1'b1) n_lost++;
    end

    task automatic cyc(input bit en, input bit d, input bit rl);
        enable  = en;
        data_in = d;
        realign = rl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_bit(input bit d, input int gap_pct);
        if (gap_pct > 0 && ($urandom % 100) < gap_pct) begin
            repeat ($urandom_range(1, 3)) cyc(1'b0, 1'($urandom), 1'b0);
        end
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic send_word(input logic [9:0] w, input int gap_pct);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], gap_pct);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) begin
            cyc(1'($urandom), 1'($urandom), 1'b0);
            cmp_en = 1;
        end
        rst = 1'b0;
        dut_words.delete();
        dut_syncs.delete();
        n_lost = 0;
    endtask

    task automatic offset_stream(input int gap_pct);
        logic [9:0] exp_w[3];
        bit         exp_s[3];
        exp_w = '{10'h155, 10'h19A, 10'h19A};
        exp_s = '{1'b0, 1'b1, 1'b1};
        do_reset();
        repeat (7) send_bit(1'($urandom), gap_pct);
        repeat (REPS) send_word(SYNC, gap_pct);
        send_word(10'h155, gap_pct);
        send_word(10'h19A, gap_pct);
        send_word(SYNC, gap_pct);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("offset_word_count", 32'(dut_words.size()), 32'd3);
        if (dut_words.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("offset_word", 32'(dut_words[i]), 32'(exp_w[i]));
                chk("offset_sync", 32'(dut_syncs[i]), 32'(exp_s[i]));
            end
        end
    endtask

    logic [9:0] rw;
    logic [9:0] sent[$];

    initial begin
        // Reset with random line activity.
        do_reset();
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_align", 32'(bit_align_done), 32'd0);
        chk("rst_sync", 32'(sync_seen), 32'd0);
        chk("rst_lost", 32'(lock_lost), 32'd0);

        // Lock then first word.
        repeat (REPS) send_word(SYNC, 0);
        chk("lock_not_yet", 32'(bit_align_done), 32'd0);
        rw = 10'h2A5;
        cyc(1'b1, rw[9], 1'b0);
        chk("lock_rise", 32'(bit_align_done), 32'd1);
        for (int i = W - 2; i >= 0; i--) cyc(1'b1, rw[i], 1'b0);
        chk("first_valid", 32'(data_valid), 32'd1);
        chk("first_word", 32'(data_out), 32'h2A5);
        chk("first_sync", 32'(sync_seen), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("first_single_pulse", 32'(data_valid), 32'd0);
        chk("first_hold", 32'(data_out), 32'h2A5);

        // Arbitrary offset, then the same with enable gaps.
        offset_stream(0);
        offset_stream(30);

        // realign mid-word, then realign colliding with a match.
        do_reset();
        repeat (REPS) send_word(SYNC, 0);
        rw = 10'h2A5;
        for (int i = W - 1; i >= W - 5; i--) cyc(1'b1, rw[i], 1'b0);
        cyc(1'b1, rw[4], 1'b1);
        chk("realign_fall", 32'(bit_align_done), 32'd0);
        for (int i = 3; i >= 0; i--) cyc(1'b1, rw[i], 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("realign_no_valid", 32'(dut_words.size()), 32'd0);
        repeat (REPS) send_word(SYNC, 0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("realign_beats_match", 32'(bit_align_done), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("relock", 32'(bit_align_done), 32'd1);
        send_word(10'h155, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("relock_word_count", 32'(dut_words.size()), 32'd1);
        chk("relock_word", 32'(dut_words[$]), 32'h155);

        // Loss of lock after TO non-header words.
        do_reset();
        sent.delete();
        repeat (REPS) send_word(SYNC, 0);
        repeat (TO + 1) begin
            rw = 10'($urandom);
            while (rw == SYNC) rw = 10'($urandom);
            sent.push_back(rw);
            send_word(rw, 0);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
`ifdef DESER_ALIGN_LOCK_LOSS_OF_LOCK_EN
        chk("lol_word_count", 32'(dut_words.size()), 32'(TO));
        chk("lol_pulses", 32'(n_lost), 32'd1);
        chk("lol_align_after", 32'(bit_align_done), 32'd0);
`else
        chk("lol_word_count", 32'(dut_words.size()), 32'(TO + 1));
        chk("lol_pulses", 32'(n_lost), 32'd0);
        chk("lol_align_after", 32'(bit_align_done), 32'd1);
`endif
        for (int i = 0; i < dut_words.size() && i < sent.size(); i++) begin
            chk("lol_word", 32'(dut_words[i]), 32'(sent[i]));
        end

        // Random traffic: header trains, words, gaps and realigns.
        do_reset();
        for (int it = 0; it < 700; it++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 20) begin
                repeat (REPS) send_word(SYNC, 20);
            end else if (sel < 65) begin
                send_word(($urandom_range(0, 5) == 0) ? SYNC : 10'($urandom), 20);
            end else if (sel < 70) begin
                cyc(1'b1, 1'($urandom), 1'b1);
            end else if (sel < 72) begin
                do_reset();
            end else begin
                repeat ($urandom_range(1, 4)) cyc(1'($urandom), 1'($urandom), 1'b0);
            end
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
